// File: rtl/operand_loader.sv
// operand_loader: stages A/B operands for the 64-lane MAC/NL demux.
// Collects BEAT_LANES-wide beats into full 64-lane vectors (with a 2-bit
// mode captured on beat 0) and presents each finished vector on a
// valid/ready output.
//
// Build option: define LOADER_DBUF_EN for ping-pong buffering (two vector
// buffers, so the next vector fills while one is held). Undefined gives a
// single buffer that refuses beats while its vector is waiting.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      beat handshake
//   in_mode                vector mode, taken from beat 0 only
//   in_a, in_b             BEAT_LANES lanes of `MAC_BW each, lane j at [j*W +: W]
//   out_valid/out_ready    vector handshake
//   out_mode, out_a, out_b presented vector (read buffer contents)
//   beat_idx               index of the next beat to be written
`ifndef MAC_BW
`define MAC_BW 8
`endif

module operand_loader #(
  parameter  int BEAT_LANES = 8,
  localparam int BEATS      = 64 / BEAT_LANES,
  localparam int BIW        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_mode,
  input  logic [BEAT_LANES*`MAC_BW-1:0]  in_a,
  input  logic [BEAT_LANES*`MAC_BW-1:0]  in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [1:0]                     out_mode,
  output logic [`MAC_BW-1:0]             out_a [63:0],
  output logic [`MAC_BW-1:0]             out_b [63:0],
  output logic [BIW-1:0]                 beat_idx
);

  localparam int W = `MAC_BW;

  logic       in_fire, out_fire, first_beat, last_beat;
  logic [1:0] count;

  assign out_valid  = (count != 2'd0);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign first_beat = (beat_idx == '0);
  assign last_beat  = (beat_idx == BIW'(BEATS - 1));

`ifdef LOADER_DBUF_EN
  // in_ready depends only on the registered occupancy, never on out_ready.
  logic       wr_ptr, rd_ptr;
  logic [1:0] mode_q [2];

  assign in_ready = (count < 2'd2);
  assign out_mode = mode_q[rd_ptr];
`else
  logic [1:0] mode_q;

  assign in_ready = (count == 2'd0);
  assign out_mode = mode_q;
`endif

  // Beat counter, occupancy and buffer pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx <= '0;
      count    <= 2'd0;
`ifdef LOADER_DBUF_EN
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
`endif
    end else begin
      if (in_fire)
        beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
      // Completing a vector and handing one off in the same cycle cancel.
      count <= count + {1'b0, in_fire && last_beat} - {1'b0, out_fire};
`ifdef LOADER_DBUF_EN
      if (in_fire && last_beat) wr_ptr <= ~wr_ptr;
      if (out_fire)             rd_ptr <= ~rd_ptr;
`endif
    end
  end

  // Mode is captured with the first beat of each vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef LOADER_DBUF_EN
      mode_q[0] <= 2'd0;
      mode_q[1] <= 2'd0;
`else
      mode_q    <= 2'd0;
`endif
    end else if (in_fire && first_beat) begin
`ifdef LOADER_DBUF_EN
      mode_q[wr_ptr] <= in_mode;
`else
      mode_q         <= in_mode;
`endif
    end
  end

  // Per-lane storage: vector lane i is loaded by beat i/BEAT_LANES from
  // input lane i%BEAT_LANES. Contents persist after hand-off.
  for (genvar i = 0; i < 64; i++) begin : g_lane
    localparam int K = i / BEAT_LANES;
    localparam int J = i % BEAT_LANES;

    logic wr;
    assign wr = in_fire && (beat_idx == BIW'(K));

`ifdef LOADER_DBUF_EN
    logic [W-1:0] a_q [2];
    logic [W-1:0] b_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q[0] <= '0;
        a_q[1] <= '0;
        b_q[0] <= '0;
        b_q[1] <= '0;
      end else if (wr) begin
        a_q[wr_ptr] <= in_a[J*W +: W];
        b_q[wr_ptr] <= in_b[J*W +: W];
      end
    end

    assign out_a[i] = a_q[rd_ptr];
    assign out_b[i] = b_q[rd_ptr];
`else
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
      end else if (wr) begin
        a_q <= in_a[J*W +: W];
        b_q <= in_b[J*W +: W];
      end
    end

    assign out_a[i] = a_q;
    assign out_b[i] = b_q;
`endif
  end

endmodule
